// File: rtl/acc_feeder.sv
// Buffers numbers in a small FIFO and feeds them to an accumulator core as spaced
// valid_o strobes framed by run_o, with a trailing run window and a done pulse.
module acc_feeder #(
    parameter int IN_DATA_WIDTH = 8,
    parameter int FIFO_DEPTH    = 8,
    parameter int CNT_WIDTH     = 8,
    parameter int GAP           = 2,
    parameter int TAIL          = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_valid_i,
    input  logic [IN_DATA_WIDTH-1:0]     wr_data_i,
    output logic                         wr_ready_o,
    input  logic                         start_i,
    input  logic [CNT_WIDTH-1:0]         len_i,
    output logic                         run_o,
    output logic                         valid_o,
    output logic [IN_DATA_WIDTH-1:0]     number_o,
    output logic                         busy_o,
    output logic                         done_o,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = $clog2(GAP + 1);
    localparam int TW = $clog2(TAIL + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, TAIL_WAIT, DONE} state_t;

    state_t                   state_q, state_d;
    logic [IN_DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]            wrPtr_q, rdPtr_q;
    logic [CW-1:0]            count_q, count_d;
    logic [CNT_WIDTH-1:0]     remain_q, remain_d;
    logic [GW-1:0]            gap_q, gap_d;
    logic [TW-1:0]            tail_q, tail_d;
    logic                     valid_q;
    logic [IN_DATA_WIDTH-1:0] number_q;
    logic                     push, pop;

    assign wr_ready_o   = (count_q != CW'(FIFO_DEPTH));
    assign push         = wr_valid_i && wr_ready_o;
    assign fifo_count_o = count_q;
    assign valid_o      = valid_q;
    assign number_o     = number_q;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage carries no reset; emptiness is tracked purely by the count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            wrPtr_q  <= '0;
            rdPtr_q  <= '0;
            count_q  <= '0;
            remain_q <= '0;
            gap_q    <= '0;
            tail_q   <= '0;
            valid_q  <= 1'b0;
            number_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            remain_q <= remain_d;
            gap_q    <= gap_d;
            tail_q   <= tail_d;
            valid_q  <= pop;
            if (push) begin
                wrPtr_q <= wrPtr_q + AW'(1);
            end
            if (pop) begin
                rdPtr_q  <= rdPtr_q + AW'(1);
                number_q <= mem[rdPtr_q];
            end
        end
    end

    // Gap counter is reloaded on each pop so the next pop lands GAP+1 cycles later.
    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        gap_d    = (gap_q != '0) ? gap_q - GW'(1) : gap_q;
        tail_d   = tail_q;
        pop      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (len_i != '0) begin
                        state_d  = ISSUE;
                        remain_d = len_i;
                        gap_d    = '0;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            ISSUE: begin
                if (count_q != '0 && gap_q == '0) begin
                    pop      = 1'b1;
                    gap_d    = GW'(GAP);
                    remain_d = remain_q - CNT_WIDTH'(1);
                    if (remain_q == CNT_WIDTH'(1)) begin
                        state_d = TAIL_WAIT;
                        tail_d  = TW'(TAIL);
                    end
                end
            end
            TAIL_WAIT: begin
                if (tail_q == '0) begin
                    state_d = DONE;
                end else begin
                    tail_d = tail_q - TW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        run_o  = (state_q == ISSUE) || (state_q == TAIL_WAIT);
        busy_o = (state_q != IDLE);
        done_o = (state_q == DONE);
    end

endmodule

// File: tb/tb_acc_feeder.sv
// Directed bench for acc_feeder: a negedge monitor logs strobes and done pulses,
// and one task per scenario checks the logs against hand-computed values.
module tb_acc_feeder;

   logic       clk;
   logic       reset;
   logic       wrValid;
   logic [7:0] wrData;
   logic       wrReady;
   logic       startReq;
   logic [7:0] lenIn;
   logic       runOut;
   logic       validOut;
   logic [7:0] numberOut;
   logic       busyOut;
   logic       doneOut;
   logic [3:0] fifoCount;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int doneCnt = 0;
   int doneCyc = 0;
   int lastRunCyc = 0;
   bit runEver = 0;
   logic [7:0] gotNums[$];
   int validCyc[$];

   acc_feeder dut (
      .clk(clk),
      .reset(reset),
      .wr_valid_i(wrValid),
      .wr_data_i(wrData),
      .wr_ready_o(wrReady),
      .start_i(startReq),
      .len_i(lenIn),
      .run_o(runOut),
      .valid_o(validOut),
      .number_o(numberOut),
      .busy_o(busyOut),
      .done_o(doneOut),
      .fifo_count_o(fifoCount)
   );

   // 10 ns clock; cycle index advances on every rising edge
   initial clk = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor records every strobe, done pulse and run window at the falling edge
   always @(negedge clk) begin
      if (validOut) begin
         gotNums.push_back(numberOut);
         validCyc.push_back(cyc);
      end
      if (doneOut) begin
         doneCnt++;
         doneCyc = cyc;
      end
      if (runOut) begin
         lastRunCyc = cyc;
         runEver = 1;
      end
   end

   // Inputs change and checks happen just after the falling edge
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic clearLogs();
      gotNums.delete();
      validCyc.delete();
      doneCnt = 0;
      runEver = 0;
   endtask

   task automatic writeWords(input int first, input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         wrValid = 1;
         wrData = 8'(first + i);
      end
      tick();
      wrValid = 0;
   endtask

   task automatic startJob(input int len);
      tick();
      startReq = 1;
      lenIn = 8'(len);
      tick();
      startReq = 0;
      lenIn = 8'hAA;
   endtask

   task automatic waitDone(input int target, input int budget, input string name);
      int n;
      n = 0;
      while (doneCnt < target && n < budget) begin
         tick();
         n++;
      end
      checks++;
      if (doneCnt < target) begin
         errors++;
         $display("[TB] FAIL %s timeout: done count %0d, required %0d", name, doneCnt, target);
      end
   endtask

   task automatic applyReset();
      tick();
      reset = 1;
      tick();
      tick();
      reset = 0;
      clearLogs();
   endtask

   task automatic test_reset();
      applyReset();
      checks++;
      if ({runOut, validOut, busyOut, doneOut} !== 4'b0000 || numberOut !== 8'd0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: run/valid/busy/done=%b number=%0d, required 0000 and 0",
                  {runOut, validOut, busyOut, doneOut}, numberOut);
      end
      checks++;
      if (fifoCount !== 4'd0 || wrReady !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_fifo: count=%0d ready=%b, required 0 and 1", fifoCount, wrReady);
      end
   endtask

   task automatic test_basic();
      int startCyc;
      clearLogs();
      tick();
      wrValid = 1; wrData = 8'd1;
      tick();
      wrData = 8'd3;
      tick();
      wrValid = 0;
      startJob(2);
      startCyc = cyc;
      checks++;
      if (runOut !== 1'b1) begin
         errors++;
         $display("[TB] FAIL basic_run_on: run=%b, required 1", runOut);
      end
      waitDone(1, 40, "basic_done");
      tick();
      checks++;
      if (gotNums.size() != 2 || gotNums[0] !== 8'd1 || gotNums[1] !== 8'd3) begin
         errors++;
         $display("[TB] FAIL basic_numbers: got %0d pulses %p, required 1 then 3", gotNums.size(), gotNums);
      end
      if (validCyc.size() == 2) begin
         checks++;
         if (validCyc[0] != startCyc + 1) begin
            errors++;
            $display("[TB] FAIL basic_first_latency: pulse at %0d, required %0d", validCyc[0], startCyc + 1);
         end
         checks++;
         if (validCyc[1] - validCyc[0] != 3) begin
            errors++;
            $display("[TB] FAIL basic_gap: spacing %0d, required 3", validCyc[1] - validCyc[0]);
         end
         checks++;
         if (lastRunCyc - validCyc[1] != 4) begin
            errors++;
            $display("[TB] FAIL basic_tail: run held %0d cycles after last pulse, required 4",
                     lastRunCyc - validCyc[1]);
         end
         checks++;
         if (doneCyc != validCyc[1] + 5) begin
            errors++;
            $display("[TB] FAIL basic_done_cycle: done at %0d, required %0d", doneCyc, validCyc[1] + 5);
         end
      end
      checks++;
      if (doneCnt != 1 || busyOut !== 1'b0) begin
         errors++;
         $display("[TB] FAIL basic_done_once: done count %0d busy=%b, required 1 and 0", doneCnt, busyOut);
      end
   endtask

   task automatic test_stall();
      clearLogs();
      startJob(3);
      repeat (10) tick();
      checks++;
      if (runOut !== 1'b1 || busyOut !== 1'b1 || gotNums.size() != 0) begin
         errors++;
         $display("[TB] FAIL stall_wait: run=%b busy=%b pulses=%0d, required 1 1 0",
                  runOut, busyOut, gotNums.size());
      end
      writeWords(5, 3);
      waitDone(1, 40, "stall_done");
      tick();
      checks++;
      if (gotNums.size() != 3 || gotNums[0] !== 8'd5 || gotNums[1] !== 8'd6 || gotNums[2] !== 8'd7) begin
         errors++;
         $display("[TB] FAIL stall_numbers: got %p, required 5 6 7", gotNums);
      end
      checks++;
      if (doneCnt != 1) begin
         errors++;
         $display("[TB] FAIL stall_done_once: done count %0d, required 1", doneCnt);
      end
   endtask

   task automatic test_full();
      clearLogs();
      for (int i = 0; i < 9; i++) begin
         tick();
         if (i == 8) begin
            checks++;
            if (wrReady !== 1'b0) begin
               errors++;
               $display("[TB] FAIL full_ready: ready=%b after 8 writes, required 0", wrReady);
            end
         end
         wrValid = 1;
         wrData = 8'(i);
      end
      tick();
      wrValid = 0;
      checks++;
      if (fifoCount !== 4'd8) begin
         errors++;
         $display("[TB] FAIL full_count: count=%0d, required 8", fifoCount);
      end
      startJob(8);
      waitDone(1, 80, "full_done");
      tick();
      checks++;
      if (gotNums.size() != 8) begin
         errors++;
         $display("[TB] FAIL full_pulse_count: got %0d, required 8", gotNums.size());
      end
      for (int i = 0; i < 8 && i < gotNums.size(); i++) begin
         checks++;
         if (gotNums[i] !== 8'(i)) begin
            errors++;
            $display("[TB] FAIL full_order[%0d]: got %0d, required %0d", i, gotNums[i], i);
         end
      end
      checks++;
      if (fifoCount !== 4'd0 || wrReady !== 1'b1) begin
         errors++;
         $display("[TB] FAIL full_drained: count=%0d ready=%b, required 0 and 1", fifoCount, wrReady);
      end
   endtask

   task automatic test_zero_len_and_ignore();
      clearLogs();
      startJob(0);
      checks++;
      if (doneOut !== 1'b1 || runOut !== 1'b0) begin
         errors++;
         $display("[TB] FAIL zero_len_done: done=%b run=%b, required 1 and 0", doneOut, runOut);
      end
      tick();
      tick();
      checks++;
      if (runEver || doneCnt != 1 || busyOut !== 1'b0) begin
         errors++;
         $display("[TB] FAIL zero_len_quiet: runEver=%0d done count=%0d busy=%b, required 0 1 0",
                  runEver, doneCnt, busyOut);
      end
      clearLogs();
      writeWords(8'h21, 2);
      startJob(2);
      tick();
      startReq = 1;
      lenIn = 8'd5;
      tick();
      startReq = 0;
      waitDone(1, 40, "ignore_done");
      repeat (6) tick();
      checks++;
      if (gotNums.size() != 2 || doneCnt != 1 || busyOut !== 1'b0) begin
         errors++;
         $display("[TB] FAIL ignore_start: pulses=%0d done count=%0d busy=%b, required 2 1 0",
                  gotNums.size(), doneCnt, busyOut);
      end
   endtask

   task automatic test_reset_mid_job();
      int n;
      clearLogs();
      writeWords(8'h10, 4);
      startJob(4);
      n = 0;
      while (gotNums.size() == 0 && n < 20) begin
         tick();
         n++;
      end
      checks++;
      if (gotNums.size() == 0) begin
         errors++;
         $display("[TB] FAIL midreset_first_pulse: no pulse within 20 cycles, required one");
      end
      reset = 1;
      #1;
      checks++;
      if ({runOut, validOut, busyOut, doneOut} !== 4'b0000 || numberOut !== 8'd0 ||
          fifoCount !== 4'd0 || wrReady !== 1'b1) begin
         errors++;
         $display("[TB] FAIL midreset_outputs: rvbd=%b number=%0d count=%0d ready=%b, required 0000 0 0 1",
                  {runOut, validOut, busyOut, doneOut}, numberOut, fifoCount, wrReady);
      end
      tick();
      reset = 0;
      repeat (10) tick();
      checks++;
      if (doneCnt != 0 || gotNums.size() != 1 || busyOut !== 1'b0 || fifoCount !== 4'd0) begin
         errors++;
         $display("[TB] FAIL midreset_after: done count=%0d pulses=%0d busy=%b count=%0d, required 0 1 0 0",
                  doneCnt, gotNums.size(), busyOut, fifoCount);
      end
   endtask

   initial begin
      reset = 1;
      wrValid = 0;
      wrData = 0;
      startReq = 0;
      lenIn = 0;
      test_reset();
      test_basic();
      test_stall();
      test_full();
      test_zero_len_and_ignore();
      test_reset_mid_job();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
